// File: rtl/scan_chain_ctrl_if.sv
// Scan controller bus: pattern/flush handshake, chain pins and unload/compare results.
// The master side drives patterns and returns the chain's scan-out; the slave is the controller.
interface scan_chain_ctrl_if #(
   parameter int unsigned CHAIN_LEN = 8
);
   logic [CHAIN_LEN-1:0] PAT;
   logic [CHAIN_LEN-1:0] EXP;
   logic [CHAIN_LEN-1:0] MASK;
   logic                 PAT_VALID;
   logic                 PAT_READY;
   logic                 FLUSH;
   logic                 SO;
   logic                 SE;
   logic                 SI;
   logic [CHAIN_LEN-1:0] RESP;
   logic                 RESP_VALID;
   logic                 BUSY;
   logic                 MISMATCH;
   logic [7:0]           FAIL_CNT;

   modport master (
      output PAT, EXP, MASK, PAT_VALID, FLUSH, SO,
      input  PAT_READY, SE, SI, RESP, RESP_VALID, BUSY, MISMATCH, FAIL_CNT
   );

   modport slave (
      input  PAT, EXP, MASK, PAT_VALID, FLUSH, SO,
      output PAT_READY, SE, SI, RESP, RESP_VALID, BUSY, MISMATCH, FAIL_CNT
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-shift controller: loads a pattern MSB-first, captures, and unloads the previous capture.
// Optional on-chip masked compare of unloaded data is enabled by defining SCAN_COMPARE_EN.
module scan_chain_ctrl #(
   parameter int unsigned CHAIN_LEN  = 8,
   parameter int unsigned CAP_CYCLES = 1
) (
   input  logic           CLK,
   input  logic           RN,
   scan_chain_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned CAP_W = $clog2(CAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CAP_W-1:0] LAST_CAP   = CAP_W'(CAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

   state_t               state;
   logic [CHAIN_LEN-2:0] shift_reg;
   logic [CHAIN_LEN-2:0] resp_sr;
   logic [CNT_W-1:0]     cnt;
   logic [CAP_W-1:0]     cap_cnt;
   logic                 have_prev;
   logic                 unload_req;
   logic                 is_flush;
   logic                 se_q;
   logic                 si_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 resp_valid_q;
   logic [CHAIN_LEN-1:0] resp_q;
   logic [CHAIN_LEN-1:0] resp_next_c;

   // Full unload word as it stands after the current edge's SO sample.
   assign resp_next_c = {resp_sr, bus.SO};

   // SI carries the pattern MSB in the cycle after accept, so shift_reg keeps only the rest.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state        <= IDLE;
         shift_reg    <= '0;
         resp_sr      <= '0;
         cnt          <= '0;
         cap_cnt      <= '0;
         have_prev    <= 1'b0;
         unload_req   <= 1'b0;
         is_flush     <= 1'b0;
         se_q         <= 1'b0;
         si_q         <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.PAT_VALID) begin
                  state      <= SHIFT;
                  shift_reg  <= bus.PAT[CHAIN_LEN-2:0];
                  si_q       <= bus.PAT[CHAIN_LEN-1];
                  se_q       <= 1'b1;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt        <= '0;
                  unload_req <= have_prev;
                  is_flush   <= 1'b0;
               end else if (bus.FLUSH && have_prev) begin
                  state      <= SHIFT;
                  shift_reg  <= '0;
                  si_q       <= 1'b0;
                  se_q       <= 1'b1;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt        <= '0;
                  unload_req <= 1'b1;
                  is_flush   <= 1'b1;
               end
            end
            SHIFT: begin
               shift_reg <= shift_reg << 1;
               resp_sr   <= resp_next_c[CHAIN_LEN-2:0];
               cnt       <= cnt + 1'b1;
               if (cnt == LAST_SHIFT) begin
                  se_q <= 1'b0;
                  si_q <= 1'b0;
                  if (unload_req) begin
                     resp_q       <= resp_next_c;
                     resp_valid_q <= 1'b1;
                  end
                  if (is_flush) begin
                     state     <= IDLE;
                     have_prev <= 1'b0;
                     ready_q   <= 1'b1;
                     busy_q    <= 1'b0;
                  end else begin
                     state   <= CAPTURE;
                     cap_cnt <= '0;
                  end
               end else begin
                  si_q <= shift_reg[CHAIN_LEN-2];
               end
            end
            CAPTURE: begin
               cap_cnt <= cap_cnt + 1'b1;
               if (cap_cnt == LAST_CAP) begin
                  state     <= IDLE;
                  have_prev <= 1'b1;
                  ready_q   <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.SE         = se_q;
   assign bus.SI         = si_q;
   assign bus.PAT_READY  = ready_q;
   assign bus.BUSY       = busy_q;
   assign bus.RESP       = resp_q;
   assign bus.RESP_VALID = resp_valid_q;

`ifdef SCAN_COMPARE_EN
   logic [CHAIN_LEN-1:0] pend_exp;
   logic [CHAIN_LEN-1:0] pend_mask;
   logic [CHAIN_LEN-1:0] cmp_exp;
   logic [CHAIN_LEN-1:0] cmp_mask;
   logic                 mismatch_q;
   logic [7:0]           fail_cnt_q;
   logic                 unload_edge_c;
   logic                 fail_c;

   assign unload_edge_c = (state == SHIFT) && (cnt == LAST_SHIFT) && unload_req;
   assign fail_c        = |((resp_next_c ^ cmp_exp) & cmp_mask);

   // Expected data follows its pattern: pending while it loads, compare while it unloads.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         pend_exp   <= '0;
         pend_mask  <= '0;
         cmp_exp    <= '0;
         cmp_mask   <= '0;
         mismatch_q <= 1'b0;
         fail_cnt_q <= '0;
      end else begin
         if (state == IDLE && bus.PAT_VALID) begin
            pend_exp  <= bus.EXP;
            pend_mask <= bus.MASK;
            cmp_exp   <= pend_exp;
            cmp_mask  <= pend_mask;
         end else if (state == IDLE && bus.FLUSH && have_prev) begin
            cmp_exp  <= pend_exp;
            cmp_mask <= pend_mask;
         end
         if (unload_edge_c && fail_c) begin
            mismatch_q <= 1'b1;
            if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
         end
      end
   end

   assign bus.MISMATCH = mismatch_q;
   assign bus.FAIL_CNT = fail_cnt_q;
`else
   logic unused_cmp_c;
   assign unused_cmp_c = ^{bus.EXP, bus.MASK};
   assign bus.MISMATCH = 1'b0;
   assign bus.FAIL_CNT = 8'd0;
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 4-flop mux-scan chain with D = ~Q, scoreboard on RESP_VALID.
module tb_scan_chain_ctrl;
`ifdef SCAN_COMPARE_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RN  = 1'b0;
   logic [3:0] chain = 4'b0000;

   scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus ();

   scan_chain_ctrl #(.CHAIN_LEN(4), .CAP_CYCLES(1)) dut (
      .CLK (CLK),
      .RN  (RN),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Chain is clocked only while the controller is busy, so it holds its capture in IDLE.
   always @(posedge CLK) begin
      if (bus.BUSY) chain <= bus.SE ? {chain[2:0], bus.SI} : ~chain;
   end
   assign bus.SO = chain[3];

   typedef struct {
      logic [3:0] resp;
      bit         fail;
   } sb_t;

   sb_t  sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   m_mism  = 1'b0;
   int   m_fc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every RESP_VALID pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (bus.RESP_VALID) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp_valid: got RESP=%0h expected no pulse", bus.RESP);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.fail) begin
               m_mism = 1'b1;
               if (m_fc != 255) m_fc++;
            end
            check("resp", 32'(bus.RESP), 32'(e.resp));
            check("mismatch", 32'(bus.MISMATCH), 32'(m_mism));
            check("fail_cnt", 32'(bus.FAIL_CNT), 32'(m_fc));
         end
      end
   end

   task automatic do_reset();
      RN = 1'b0;
      repeat (2) @(negedge CLK);
      m_mism = 1'b0;
      m_fc   = 0;
      RN = 1'b1;
   endtask

   // mode 0: pattern, 1: flush, 2: pattern and flush together
   task automatic do_op(input int mode, input logic [3:0] p, input logic [3:0] e,
                        input logic [3:0] m, input bit unload, input logic [3:0] exp_resp,
                        input bit exp_fail, input int exp_low, input string name);
      int guard;
      int se_n;
      int low_n;
      sb_t ent;
      guard = 0;
      while (!bus.PAT_READY && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      check({name, "_ready"}, 32'(bus.PAT_READY), 32'd1);
      if (unload) begin
         ent.resp = exp_resp;
         ent.fail = exp_fail & CMP;
         sb_q.push_back(ent);
      end
      bus.PAT       = p;
      bus.EXP       = e;
      bus.MASK      = m;
      bus.PAT_VALID = (mode != 1);
      bus.FLUSH     = (mode != 0);
      @(posedge CLK);
      #1;
      bus.PAT_VALID = 1'b0;
      bus.FLUSH     = 1'b0;
      se_n  = 0;
      low_n = 0;
      guard = 0;
      forever begin
         @(negedge CLK);
         if (bus.PAT_READY || guard >= 100) break;
         low_n++;
         if (bus.SE) se_n++;
         guard++;
      end
      check({name, "_ready_low"}, 32'(low_n), 32'(exp_low));
      check({name, "_se_cycles"}, 32'(se_n), 32'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bus.PAT = '0; bus.EXP = '0; bus.MASK = '0;
      bus.PAT_VALID = 1'b0; bus.FLUSH = 1'b0;
      do_reset();

      check("rst_se",        32'(bus.SE),         32'd0);
      check("rst_si",        32'(bus.SI),         32'd0);
      check("rst_ready",     32'(bus.PAT_READY),  32'd1);
      check("rst_busy",      32'(bus.BUSY),       32'd0);
      check("rst_resp",      32'(bus.RESP),       32'd0);
      check("rst_resp_vld",  32'(bus.RESP_VALID), 32'd0);
      check("rst_mismatch",  32'(bus.MISMATCH),   32'd0);
      check("rst_fail_cnt",  32'(bus.FAIL_CNT),   32'd0);

      // FLUSH with nothing captured is ignored
      bus.FLUSH = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("idle_flush_busy", 32'(bus.BUSY), 32'd0);
      end
      bus.FLUSH = 1'b0;

      // 1011 captured through ~Q gives 0100
      do_op(0, 4'b1011, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5, "load1011");
      do_op(1, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0100, 1'b0, 4, "flush1");

      // Back-to-back, each load unloads the previous capture
      do_op(0, 4'b0001, 4'h0, 4'h0, 1'b0, 4'h0,    1'b0, 5, "load0001");
      do_op(0, 4'b1111, 4'h0, 4'h0, 1'b1, 4'b1110, 1'b0, 5, "load1111");
      do_op(1, 4'h0,    4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 4, "flush2");

      // PAT_VALID wins over FLUSH
      do_op(0, 4'b0011, 4'h0, 4'h0, 1'b0, 4'h0,    1'b0, 5, "load0011");
      do_op(2, 4'b0101, 4'h0, 4'h0, 1'b1, 4'b1100, 1'b0, 5, "both");
      do_op(1, 4'h0,    4'h0, 4'h0, 1'b1, 4'b1010, 1'b0, 4, "flush3");

      // Reset on the 2nd shift edge discards the in-flight unload
      do_op(0, 4'b1001, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5, "load1001");
      bus.PAT = 4'b0110;
      bus.PAT_VALID = 1'b1;
      @(posedge CLK);
      #1 bus.PAT_VALID = 1'b0;
      @(posedge CLK);
      #1 RN = 1'b0;
      @(posedge CLK);
      #1 RN = 1'b1;
      m_mism = 1'b0;
      m_fc   = 0;
      @(negedge CLK);
      check("midrst_se",    32'(bus.SE),        32'd0);
      check("midrst_si",    32'(bus.SI),        32'd0);
      check("midrst_ready", 32'(bus.PAT_READY), 32'd1);
      check("midrst_busy",  32'(bus.BUSY),      32'd0);
      bus.FLUSH = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("midrst_flush_busy", 32'(bus.BUSY), 32'd0);
      end
      bus.FLUSH = 1'b0;

      // Masked compare: bit1 differs and is compared
      do_reset();
      do_op(0, 4'b1011, 4'b0110, 4'b0011, 1'b0, 4'h0,    1'b0, 5, "cmp_load_a");
      do_op(1, 4'h0,    4'h0,    4'h0,    1'b1, 4'b0100, 1'b1, 4, "cmp_flush_a");
      check("cmp_a_mismatch", 32'(bus.MISMATCH), 32'(CMP));
      check("cmp_a_fail_cnt", 32'(bus.FAIL_CNT), 32'(CMP));

      // Same data, differing bit masked off
      do_reset();
      do_op(0, 4'b1011, 4'b0110, 4'b1101, 1'b0, 4'h0,    1'b0, 5, "cmp_load_b");
      do_op(1, 4'h0,    4'h0,    4'h0,    1'b1, 4'b0100, 1'b0, 4, "cmp_flush_b");
      check("cmp_b_mismatch", 32'(bus.MISMATCH), 32'd0);
      check("cmp_b_fail_cnt", 32'(bus.FAIL_CNT), 32'd0);

      // 257 failing unloads saturate the counter
      do_reset();
      for (int i = 0; i < 257; i++) begin
         do_op(0, 4'b1011, 4'b0110, 4'b0011, (i != 0), 4'b0100, 1'b1, 5, "sat");
      end
      do_op(1, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0100, 1'b1, 4, "sat_flush");
      check("sat_fail_cnt", 32'(bus.FAIL_CNT), CMP ? 32'd255 : 32'd0);
      check("sat_mismatch", 32'(bus.MISMATCH), 32'(CMP));

      repeat (3) @(negedge CLK);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
